uart_tx_scheduler: RTL and testbench

//  Shares one UART serial TX line between NUM_REQ requesters (e.g. slave driver BFM

---
 rtl/uart_sched_pkg.sv | 18 +
 rtl/uart_rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART TX scheduler slice.
package uart_sched_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  function automatic int baud_cnt_w(input int cpb);
    return $clog2(cpb);
  endfunction

  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

  function automatic int frame_len(input int cpb, input int dw, input int par, input int stop);
    return cpb * (1 + dw + par + stop);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: search starts one past ptr and wraps; one-hot grant plus its index.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    gnt = (en && found) ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line among NUM_REQ requesters: RR grant, byte capture, framed serialisation.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            frame_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = baud_cnt_w(CLKS_PER_BIT);
  localparam int CW = bit_cnt_w(DATA_WIDTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  uart_tx_state_e                      state;
  logic [BW-1:0]                       baud_cnt;
  logic [CW-1:0]                       bit_cnt;
  logic [DATA_WIDTH-1:0]               shreg;
  logic                                par_bit;
  logic [IW-1:0]                       rr_ptr;
  logic [IW-1:0]                       win_idx;
  logic [NUM_REQ-1:0]                  gnt;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_vec;
  logic [DATA_WIDTH-1:0]               win_data;
  logic                                baud_tc;

  assign req_vec   = req_data;
  assign win_data  = req_vec[win_idx];
  assign baud_tc   = (baud_cnt == BAUD_LAST);
  assign req_ready = gnt;

  // Gated by rst so no handshake can be offered while reset is held.
  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  ((state == IDLE) && !rst),
    .gnt (gnt),
    .idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      grant_id   <= '0;
      rr_ptr     <= IW'(NUM_REQ - 1);  // requester 0 searched first
    end else begin
      frame_done <= 1'b0;
      baud_cnt   <= (state == IDLE || baud_tc) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: if (|gnt) begin
          state    <= START;
          tx       <= 1'b0;
          busy     <= 1'b1;
          shreg    <= win_data;
          par_bit  <= (^win_data) ^ (PARITY_ODD != 0);
          grant_id <= win_idx;
          rr_ptr   <= win_idx;
        end
        START: if (baud_tc) begin
          state <= DATA;
          tx    <= shreg[0];
        end
        DATA: if (baud_tc) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            if (PARITY_EN != 0) begin
              state <= PARITY;
              tx    <= par_bit;
            end else begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
          end
        end
        PARITY: if (baud_tc) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: begin
          // Registered pulse lands in the final cycle of the last stop bit.
          if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE) frame_done <= 1'b1;
          if (baud_tc) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: default-config DUT plus an odd-parity / 2-stop-bit DUT on the same clock.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid, b_req_valid;
  logic [31:0] req_data, b_req_data;
  logic [3:0]  req_ready, b_req_ready;
  logic        tx, b_tx, busy, b_busy, frame_done, b_frame_done;
  logic [1:0]  grant_id, b_grant_id;

  int checks = 0;
  int failures = 0;

  uart_tx_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done)
  );

  uart_tx_scheduler #(.PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .tx(b_tx), .busy(b_busy), .grant_id(b_grant_id),
    .frame_done(b_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready_t0 got=%b exp=0000", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0000 || frame_done !== 1'b0 || grant_id !== 2'd0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got tx=%b busy=%b ready=%b fd=%b gid=%0d exp 1 0 0000 0 0",
                 i, tx, busy, req_ready, frame_done, grant_id);
      end
    end
    req_valid = 4'h0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    logic [10:0] exp_bits;
    exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    req_data[16 +: 8] = 8'hA5;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd2) begin
      failures++; $display("FAIL single_start got ready=%b busy=%b gid=%0d exp 0000 1 2", req_ready, busy, grant_id);
    end
    for (int n = 0; n < 176; n++) begin
      checks++;
      if (tx !== exp_bits[n/16]) begin
        failures++; $display("FAIL single_tx n=%0d got=%b exp=%b", n, tx, exp_bits[n/16]);
      end
      checks++;
      if (frame_done !== (n == 175)) begin
        failures++; $display("FAIL single_frame_done n=%0d got=%b exp=%b", n, frame_done, (n == 175));
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || frame_done !== 1'b0) begin
      failures++; $display("FAIL single_end got busy=%b tx=%b fd=%b exp 0 1 0", busy, tx, frame_done);
    end
  endtask

  task automatic test_round_robin;
    int ord[5] = '{0, 1, 2, 3, 0};
    int t;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data = 32'h44332211;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_ready !== (4'b0001 << ord[k])) begin
        failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << ord[k]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'(ord[k])) begin
        failures++; $display("FAIL rr_grant k=%0d got busy=%b gid=%0d exp 1 %0d", k, busy, grant_id, ord[k]);
      end
      t = 0;
      while (frame_done !== 1'b1 && t < 400) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 400) begin
        failures++; $display("FAIL rr_timeout k=%0d got no frame_done exp within 400 clks", k);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        failures++; $display("FAIL rr_idle_gap k=%0d got busy=%b tx=%b exp 0 1", k, busy, tx);
      end
    end
    req_valid = 4'h0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rr_stop got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_parity_stop;
    logic exp_tx;
    b_req_data[7:0] = 8'h00;
    b_req_valid = 4'b0001;
    #1;
    checks++;
    if (b_req_ready !== 4'b0001) begin
      failures++; $display("FAIL odd_ready got=%b exp=0001", b_req_ready);
    end
    @(negedge clk);
    b_req_valid = 4'b0000;
    for (int n = 0; n < 192; n++) begin
      exp_tx = (n >= 144);
      checks++;
      if (b_tx !== exp_tx || b_busy !== 1'b1) begin
        failures++; $display("FAIL odd_tx n=%0d got tx=%b busy=%b exp %b 1", n, b_tx, b_busy, exp_tx);
      end
      checks++;
      if (b_frame_done !== (n == 191)) begin
        failures++; $display("FAIL odd_frame_done n=%0d got=%b exp=%b", n, b_frame_done, (n == 191));
      end
      @(negedge clk);
    end
    checks++;
    if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
      failures++; $display("FAIL odd_end got busy=%b tx=%b exp 0 1", b_busy, b_tx);
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    int t;
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    // n=0 is START entry; data bit 3 occupies n=64..79
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL midrst_state got tx=%b busy=%b fd=%b exp 1 0 0", tx, busy, frame_done);
    end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL midrst_quiet got %0d bad cycles exp 0", bad);
    end
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL midrst_rr_ready got=%b exp=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL midrst_grant got gid=%0d busy=%b exp 0 1", grant_id, busy);
    end
    t = 0;
    while (frame_done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 400) begin
      failures++; $display("FAIL midrst_timeout got no frame_done exp within 400 clks");
    end
    @(negedge clk);
  endtask

  task automatic test_data_hold;
    logic [7:0] got;
    logic       par;
    got = 8'h00;
    par = 1'b1;
    req_data[7:0] = 8'hC3;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    req_data[7:0] = 8'h00;
    for (int n = 0; n < 176; n++) begin
      if (n % 16 == 8 && n / 16 >= 1 && n / 16 <= 8) got[n/16 - 1] = tx;
      if (n == 152) par = tx;
      @(negedge clk);
    end
    checks++;
    if (got !== 8'hC3) begin
      failures++; $display("FAIL hold_data got=%h exp=c3", got);
    end
    checks++;
    if (par !== 1'b0) begin
      failures++; $display("FAIL hold_parity got=%b exp=0", par);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL hold_end got busy=%b exp=0", busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'h0;
    req_data = 32'h0;
    b_req_valid = 4'h0;
    b_req_data = 32'h0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_parity_stop();
    test_reset_mid_frame();
    test_data_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
